// File: rtl/cpu15_defs.sv
// rtl/cpu15_defs.sv - shared stage codes, monitor state encodings and error codes
// for the 15-bit CPU stage-clock generator and its phase monitor.
package cpu15_defs;

  typedef enum logic [1:0] {
    FT_STAGE = 2'b00,
    DC_STAGE = 2'b01,
    EX_STAGE = 2'b10,
    WB_STAGE = 2'b11
  } stage_e;

  typedef enum logic [1:0] {
    UNLOCKED = 2'b00,
    TRACK    = 2'b01,
    LOCKED   = 2'b10,
    FAULT    = 2'b11
  } mon_state_e;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_DROP  = 2'b01;
  localparam logic [1:0] ERR_MULTI = 2'b10;
  localparam logic [1:0] ERR_ORDER = 2'b11;

endpackage

// File: rtl/phase_mon_if.sv
// rtl/phase_mon_if.sv - four-phase stage-clock lines plus monitor status outputs.
interface phase_mon_if #(
  parameter int CNT_W = 16
);

  logic             CLK_FT;
  logic             CLK_DC;
  logic             CLK_EX;
  logic             CLK_WB;
  logic             CLR_ERR;
  logic [1:0]       STAGE;
  logic             LOCKED;
  logic             ERR;
  logic [1:0]       ERR_CODE;
  logic [CNT_W-1:0] INSTR_CNT;

  modport master (
    output CLK_FT, CLK_DC, CLK_EX, CLK_WB, CLR_ERR,
    input  STAGE, LOCKED, ERR, ERR_CODE, INSTR_CNT
  );

  modport slave (
    input  CLK_FT, CLK_DC, CLK_EX, CLK_WB, CLR_ERR,
    output STAGE, LOCKED, ERR, ERR_CODE, INSTR_CNT
  );

endinterface

// File: rtl/phase_dec.sv
// rtl/phase_dec.sv - classifies a 4-bit phase sample as one-hot, all-zero or multi-hot
// and returns the index of the set bit when one-hot.
module phase_dec
  import cpu15_defs::*;
(
  input  logic [3:0] ph,
  output logic       onehot,
  output logic       zero,
  output logic       multi,
  output logic [1:0] idx
);

  // Any X/Z bit falls to the default arm, so such a sample is never one-hot.
  always_comb begin
    onehot = 1'b0;
    idx    = FT_STAGE;
    case (ph)
      4'b0001: begin onehot = 1'b1; idx = FT_STAGE; end
      4'b0010: begin onehot = 1'b1; idx = DC_STAGE; end
      4'b0100: begin onehot = 1'b1; idx = EX_STAGE; end
      4'b1000: begin onehot = 1'b1; idx = WB_STAGE; end
      default: ;
    endcase
  end

  assign zero  = (ph == 4'b0000);
  assign multi = ((ph & (ph - 4'd1)) != 4'b0000);

endmodule

// File: rtl/phase_mon.sv
// rtl/phase_mon.sv - stage-clock receiver: acquires lock on clean FT->DC->EX->WB
// rotations, flags protocol violations and counts instruction cycles once locked.
module phase_mon
  import cpu15_defs::*;
#(
  parameter int LOCK_CYC = 2,
  parameter int CNT_W    = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  phase_mon_if.slave  bus
);

  mon_state_e       state, state_n;
  logic [1:0]       stage, stage_n;
  logic             locked, locked_n;
  logic             err, err_n;
  logic [1:0]       err_code, err_code_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       rot, rot_n;

  logic       onehot, zero, multi;
  logic [1:0] idx;
  logic [1:0] exp_idx;
  logic [3:0] rot_inc;
  logic       in_order;

  phase_dec u_dec (
    .ph     ({bus.CLK_WB, bus.CLK_EX, bus.CLK_DC, bus.CLK_FT}),
    .onehot (onehot),
    .zero   (zero),
    .multi  (multi),
    .idx    (idx)
  );

  assign exp_idx  = stage + 2'd1;
  assign rot_inc  = rot + 4'd1;
  assign in_order = onehot && (idx == exp_idx);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= UNLOCKED;
      stage    <= FT_STAGE;
      locked   <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      cnt      <= '0;
      rot      <= '0;
    end else begin
      state    <= state_n;
      stage    <= stage_n;
      locked   <= locked_n;
      err      <= err_n;
      err_code <= err_code_n;
      cnt      <= cnt_n;
      rot      <= rot_n;
    end
  end

  always_comb begin
    state_n    = state;
    stage_n    = stage;
    locked_n   = locked;
    err_n      = err;
    err_code_n = err_code;
    cnt_n      = cnt;
    rot_n      = rot;
    case (state)
      UNLOCKED: begin
        // The capturing sample only seeds STAGE; it never counts as a rotation.
        if (onehot) begin
          stage_n = idx;
          rot_n   = '0;
          state_n = TRACK;
        end
      end
      TRACK: begin
        if (in_order) begin
          stage_n = idx;
          if (idx == WB_STAGE) begin
            if (rot_inc == 4'(LOCK_CYC)) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
              rot_n    = '0;
            end else begin
              rot_n = rot_inc;
            end
          end
        end else begin
          state_n = UNLOCKED;
          rot_n   = '0;
        end
      end
      LOCKED: begin
        if (in_order) begin
          stage_n = idx;
          if (idx == WB_STAGE) cnt_n = cnt + 1'b1;
        end else begin
          state_n  = FAULT;
          locked_n = 1'b0;
          err_n    = 1'b1;
          if (multi)     err_code_n = ERR_MULTI;
          else if (zero) err_code_n = ERR_DROP;
          else           err_code_n = ERR_ORDER;
        end
      end
      FAULT: begin
        if (bus.CLR_ERR) begin
          state_n    = UNLOCKED;
          err_n      = 1'b0;
          err_code_n = ERR_NONE;
        end
      end
      default: state_n = UNLOCKED;
    endcase
  end

  assign bus.STAGE     = stage;
  assign bus.LOCKED    = locked;
  assign bus.ERR       = err;
  assign bus.ERR_CODE  = err_code;
  assign bus.INSTR_CNT = cnt;

endmodule

// File: tb/tb_phase_mon.sv
// tb/tb_phase_mon.sv - directed bench for phase_mon with queued expectations
// checked one clock after each driven sample.
module tb_phase_mon;

  localparam int CW = 4;
  localparam logic [3:0] P_FT = 4'b0001;
  localparam logic [3:0] P_DC = 4'b0010;
  localparam logic [3:0] P_EX = 4'b0100;
  localparam logic [3:0] P_WB = 4'b1000;

  typedef struct {
    string          tag;
    logic [1:0]     st;
    logic           lk;
    logic           er;
    logic [1:0]     cd;
    logic [CW-1:0]  cn;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phase_mon_if #(.CNT_W(CW)) bus ();

  phase_mon #(.LOCK_CYC(2), .CNT_W(CW)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  exp_t          q[$];
  int            n_vec = 0;
  int            n_bad = 0;
  logic [CW-1:0] ecnt;

  function automatic logic [3:0] ph_of(input int s);
    logic [3:0] one;
    one = 4'b0001;
    return one << s;
  endfunction

  task automatic check(input exp_t e);
    n_vec++;
    if (bus.STAGE !== e.st || bus.LOCKED !== e.lk || bus.ERR !== e.er ||
        bus.ERR_CODE !== e.cd || bus.INSTR_CNT !== e.cn) begin
      n_bad++;
      $display("FAIL %s: got stage=%0d locked=%0b err=%0b code=%0d cnt=%0d, want stage=%0d locked=%0b err=%0b code=%0d cnt=%0d",
               e.tag, bus.STAGE, bus.LOCKED, bus.ERR, bus.ERR_CODE, bus.INSTR_CNT,
               e.st, e.lk, e.er, e.cd, e.cn);
    end
  endtask

  task automatic chk_zero(input string tag);
    exp_t e;
    e.tag = tag; e.st = 2'd0; e.lk = 1'b0; e.er = 1'b0; e.cd = 2'd0; e.cn = '0;
    check(e);
  endtask

  task automatic drive(input string tag, input logic [3:0] ph, input logic clr,
                       input logic [1:0] st, input logic lk, input logic er,
                       input logic [1:0] cd, input logic [CW-1:0] cn);
    exp_t e;
    @(negedge clk);
    {bus.CLK_WB, bus.CLK_EX, bus.CLK_DC, bus.CLK_FT} = ph;
    bus.CLR_ERR = clr;
    e.tag = tag; e.st = st; e.lk = lk; e.er = er; e.cd = cd; e.cn = cn;
    q.push_back(e);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    {bus.CLK_WB, bus.CLK_EX, bus.CLK_DC, bus.CLK_FT} = 4'b0000;
    bus.CLR_ERR = 1'b0;
    rst_n = 1'b0;
    #1 chk_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Two clean rotations from FT; lock appears after the eighth edge.
  task automatic acquire(input string tag, input logic [CW-1:0] cn, input bit clr_toggle);
    for (int k = 0; k < 8; k++)
      drive(tag, ph_of(k % 4), clr_toggle & k[0], 2'(k % 4), k == 7, 1'b0, 2'd0, cn);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    {bus.CLK_WB, bus.CLK_EX, bus.CLK_DC, bus.CLK_FT} = 4'b0000;
    bus.CLR_ERR = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    acquire("acq", '0, 1'b0);
    ecnt = '0;
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < 4; s++) begin
        if (s == 3) ecnt = ecnt + 1'b1;
        drive("run", ph_of(s), 1'b0, 2'(s), 1'b1, 1'b0, 2'd0, ecnt);
      end

    drive("ord_ft",  P_FT, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd3);
    drive("ord_dc",  P_DC, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 4'd3);
    drive("ord_bad", P_DC, 1'b0, 2'd1, 1'b0, 1'b1, 2'd3, 4'd3);
    drive("ign_ex",  P_EX, 1'b0, 2'd1, 1'b0, 1'b1, 2'd3, 4'd3);
    drive("ign_wb",  P_WB, 1'b0, 2'd1, 1'b0, 1'b1, 2'd3, 4'd3);
    drive("clr1",    P_WB, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 4'd3);

    for (int k = 0; k < 7; k++)
      drive("dcstart", ph_of((k + 1) % 4), 1'b0, 2'((k + 1) % 4), k == 6, 1'b0, 2'd0, 4'd3);

    drive("drop",   4'b0000, 1'b0, 2'd3, 1'b0, 1'b1, 2'd1, 4'd3);
    drive("drop_h", P_FT,    1'b0, 2'd3, 1'b0, 1'b1, 2'd1, 4'd3);
    drive("clr2",   4'b0000, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 4'd3);
    acquire("relock", 4'd3, 1'b0);

    drive("multi", P_FT | P_EX, 1'b1, 2'd3, 1'b0, 1'b1, 2'd2, 4'd3);
    drive("clr3",  4'b0000,     1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 4'd3);

    drive("trk_ft",   P_FT,    1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 4'd3);
    drive("trk_bad",  P_EX,    1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd3);
    drive("unl_zero", 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 4'd3);
    drive("unl_wb",   P_WB,    1'b0, 2'd3, 1'b0, 1'b0, 2'd0, 4'd3);
    acquire("wb_seed", 4'd3, 1'b1);

    do_reset("reset2");
    acquire("acq2", '0, 1'b0);
    ecnt = '0;
    for (int r = 0; r < 17; r++)
      for (int s = 0; s < 4; s++) begin
        if (s == 3) ecnt = ecnt + 1'b1;
        drive("wrap", ph_of(s), 1'b0, 2'(s), 1'b1, 1'b0, 2'd0, ecnt);
      end
    drive("pre_ft", P_FT, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd1);
    drive("pre_dc", P_DC, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 4'd1);
    drive("pre_ex", P_EX, 1'b0, 2'd2, 1'b1, 1'b0, 2'd0, 4'd1);
    @(posedge clk);
    #3;
    {bus.CLK_WB, bus.CLK_EX, bus.CLK_DC, bus.CLK_FT} = 4'b0000;
    rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive("reacq_zero", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'd0);
    drive("reacq_ex",   P_EX,    1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 4'd0);
    drive("reacq_wb",   P_WB,    1'b0, 2'd3, 1'b0, 1'b0, 2'd0, 4'd0);

    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
